// File: rtl/nexus_ingress_admission.sv
// nexus_ingress_admission
// Ingress admission stage in front of the Nexus PIFO. Requests are buffered in
// a small FIFO; the head is decided every cycle (unless held) against its
// tenant's occupancy quota and the global PIFO capacity, and is either pushed
// to the PIFO or dropped. Departures reported by the pop side return credit.
//
// Ports:
//   i_clk, i_arst             clock (rising edge), async active-high reset
//   i_in_valid/o_in_ready     request handshake, i_in_data = tenant|meta|prio
//   i_hold                    freeze decisions (FIFO still fills)
//   o_push/o_push_data        one-cycle push strobe and word to the PIFO
//   o_drop/o_drop_tenant      one-cycle drop strobe and dropped tenant
//   i_deq_valid/i_deq_tenant  one PIFO entry of that tenant departed
//   i_cfg_we/_tenant/_quota   per-tenant quota write
//   o_global_cnt              admitted-not-departed entries
//   o_drop_cnt                saturating drop total
//   o_err                     sticky counter underflow flag
module nexus_ingress_admission #(
  parameter int PTW       = 16,
  parameter int MTW       = 32,
  parameter int TENANTS   = 16,
  parameter int TIDW      = 4,
  parameter int QW        = 8,
  parameter int CAP       = 1024,
  parameter int DEF_QUOTA = 64,
  parameter int DEPTH     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [MTW+PTW-1:0]      i_in_data,
  input  logic                    i_hold,
  output logic                    o_push,
  output logic [MTW+PTW-1:0]      o_push_data,
  input  logic                    i_deq_valid,
  input  logic [TIDW-1:0]         i_deq_tenant,
  input  logic                    i_cfg_we,
  input  logic [TIDW-1:0]         i_cfg_tenant,
  input  logic [QW-1:0]           i_cfg_quota,
  output logic                    o_drop,
  output logic [TIDW-1:0]         o_drop_tenant,
  output logic [$clog2(CAP):0]    o_global_cnt,
  output logic [31:0]             o_drop_cnt,
  output logic                    o_err
);

  localparam int DW = MTW + PTW;
  localparam int PW = $clog2(DEPTH);
  localparam int GW = $clog2(CAP) + 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [GW-1:0] CAP_C   = GW'(CAP);
  localparam logic [QW-1:0] DEFQ_C  = QW'(DEF_QUOTA);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [DW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic [QW-1:0]   r_occ   [TENANTS];
  logic [QW-1:0]   r_quota [TENANTS];
  logic [GW-1:0]   r_glob;
  logic            r_push, r_drop, r_err;
  logic [DW-1:0]   r_push_data;
  logic [TIDW-1:0] r_drop_tenant;
  logic [31:0]     r_drop_cnt;

  logic            w_wr, w_pop, w_admit, w_drop, w_underflow;
  logic [DW-1:0]   w_head;
  logic [TIDW-1:0] w_tenant;
  logic [TENANTS-1:0] w_occ_inc, w_occ_dec;

  // Ready depends only on the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign o_in_ready = (r_count < DEPTH_C);
  assign w_wr       = i_in_valid && o_in_ready;
  assign w_pop      = (r_count != '0) && !i_hold;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_tenant   = w_head[DW-1 -: TIDW];
  // Decision uses pre-edge counters; a same-cycle departure does not count.
  assign w_admit    = w_pop && (r_occ[w_tenant] < r_quota[w_tenant]) && (r_glob < CAP_C);
  assign w_drop     = w_pop && !w_admit;

  always_comb begin
    w_occ_inc = '0;
    w_occ_dec = '0;
    for (int i = 0; i < TENANTS; i++) begin
      w_occ_inc[i] = w_admit && (w_tenant == TIDW'(i));
      w_occ_dec[i] = i_deq_valid && (i_deq_tenant == TIDW'(i));
    end
  end

  // An admit and a departure of the same counter cancel, so underflow is only
  // flagged when the departure is not offset by a same-cycle admit.
  assign w_underflow = i_deq_valid &&
    (((r_occ[i_deq_tenant] == '0) && !(w_admit && (w_tenant == i_deq_tenant))) ||
     ((r_glob == '0) && !w_admit));

  // ---- ingress FIFO storage (data, not reset) ----
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_in_data;
  end

  // ---- ingress FIFO control ----
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_wr) r_count <= r_count - (PW+1)'(1);
    end
  end

  // ---- occupancy, quota and global accounting ----
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < TENANTS; i++) begin
        r_occ[i]   <= '0;
        r_quota[i] <= DEFQ_C;
      end
      r_glob <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < TENANTS; i++) begin
        if (w_occ_inc[i] && !w_occ_dec[i])
          r_occ[i] <= r_occ[i] + QW'(1);
        else if (w_occ_dec[i] && !w_occ_inc[i] && (r_occ[i] != '0))
          r_occ[i] <= r_occ[i] - QW'(1);
        if (i_cfg_we && (i_cfg_tenant == TIDW'(i)))
          r_quota[i] <= i_cfg_quota;
      end
      if (w_admit && !i_deq_valid)
        r_glob <= r_glob + GW'(1);
      else if (i_deq_valid && !w_admit && (r_glob != '0))
        r_glob <= r_glob - GW'(1);
      if (w_underflow) r_err <= 1'b1;
    end
  end

  // ---- registered decision outputs ----
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_push        <= 1'b0;
      r_drop        <= 1'b0;
      r_push_data   <= '0;
      r_drop_tenant <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_push <= w_admit;
      r_drop <= w_drop;
      if (w_admit) r_push_data <= w_head;
      if (w_drop) begin
        r_drop_tenant <= w_tenant;
        r_drop_cnt    <= sat_inc32(r_drop_cnt);
      end
    end
  end

  assign o_push        = r_push;
  assign o_push_data   = r_push_data;
  assign o_drop        = r_drop;
  assign o_drop_tenant = r_drop_tenant;
  assign o_global_cnt  = r_glob;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_nexus_ingress_admission.sv
module tb_nexus_ingress_admission;
  localparam int PTW = 16, MTW = 32, TENANTS = 16, TIDW = 4, QW = 8;
  localparam int CAP = 1024, DEF_QUOTA = 64, DEPTH = 4;
  localparam int DW = MTW + PTW;
  localparam int GW = $clog2(CAP) + 1;

  logic            clk = 1'b0;
  logic            i_arst = 1'b1;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [DW-1:0]   i_in_data = '0;
  logic            i_hold = 1'b0;
  logic            o_push;
  logic [DW-1:0]   o_push_data;
  logic            i_deq_valid = 1'b0;
  logic [TIDW-1:0] i_deq_tenant = '0;
  logic            i_cfg_we = 1'b0;
  logic [TIDW-1:0] i_cfg_tenant = '0;
  logic [QW-1:0]   i_cfg_quota = '0;
  logic            o_drop;
  logic [TIDW-1:0] o_drop_tenant;
  logic [GW-1:0]   o_global_cnt;
  logic [31:0]     o_drop_cnt;
  logic            o_err;

  always #5 clk = ~clk;

  nexus_ingress_admission #(
    .PTW(PTW), .MTW(MTW), .TENANTS(TENANTS), .TIDW(TIDW), .QW(QW),
    .CAP(CAP), .DEF_QUOTA(DEF_QUOTA), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_arst(i_arst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_hold(i_hold), .o_push(o_push), .o_push_data(o_push_data),
    .i_deq_valid(i_deq_valid), .i_deq_tenant(i_deq_tenant),
    .i_cfg_we(i_cfg_we), .i_cfg_tenant(i_cfg_tenant), .i_cfg_quota(i_cfg_quota),
    .o_drop(o_drop), .o_drop_tenant(o_drop_tenant), .o_global_cnt(o_global_cnt),
    .o_drop_cnt(o_drop_cnt), .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue-based FIFO plus plain counters.
  logic [DW-1:0]   mq[$];
  logic [DW-1:0]   pend[$];
  int              m_occ[TENANTS];
  int              m_quota[TENANTS];
  int              m_glob;
  longint          m_dcnt;
  bit              m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < TENANTS; i++) begin
      m_occ[i] = 0;
      m_quota[i] = DEF_QUOTA;
    end
    m_glob = 0;
    m_dcnt = 0;
    m_err  = 0;
  endtask

  function automatic logic [DW-1:0] mk_req(input int t, input logic [PTW-1:0] prio);
    logic [MTW-TIDW-1:0] meta;
    meta = (MTW-TIDW)'($urandom);
    return {TIDW'(t), meta, prio};
  endfunction

  // One clock: drive source, predict, advance, compare.
  task automatic cyc();
    bit rdy, acc, pop, adm;
    logic [DW-1:0] head, din;
    int t, dt;
    bit dv, cw;
    int ct, cq;
    i_in_valid = (pend.size() > 0);
    i_in_data  = i_in_valid ? pend[0] : '0;
    rdy = (mq.size() < DEPTH);
    chk("in_ready", o_in_ready, rdy);
    acc = i_in_valid && rdy;
    din = i_in_data;
    dv = i_deq_valid; dt = int'(i_deq_tenant);
    cw = i_cfg_we; ct = int'(i_cfg_tenant); cq = int'(i_cfg_quota);
    pop = (mq.size() > 0) && !i_hold;
    adm = 0; t = 0; head = '0;
    if (pop) begin
      head = mq[0];
      t = int'(head[DW-1 -: TIDW]);
      adm = (m_occ[t] < m_quota[t]) && (m_glob < CAP);
    end
    @(posedge clk); #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(din);
      void'(pend.pop_front());
    end
    if (adm) begin
      m_occ[t]++;
      m_glob++;
    end else if (pop && m_dcnt < 64'hFFFF_FFFF) begin
      m_dcnt++;
    end
    if (dv) begin
      if (m_occ[dt] == 0) m_err = 1; else m_occ[dt]--;
      if (m_glob == 0) m_err = 1; else m_glob--;
    end
    if (cw) m_quota[ct] = cq;
    i_deq_valid = 1'b0;
    i_cfg_we    = 1'b0;
    chk("push", o_push, adm);
    chk("drop", o_drop, pop && !adm);
    if (adm) chk("push_data", o_push_data, head);
    if (pop && !adm) chk("drop_tenant", o_drop_tenant, t);
    chk("global_cnt", o_global_cnt, m_glob);
    chk("drop_cnt", o_drop_cnt, m_dcnt);
    chk("err", o_err, m_err);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((mq.size() > 0 || pend.size() > 0) && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_bound", (mq.size() == 0 && pend.size() == 0), 1);
    cyc();
    cyc();
  endtask

  task automatic set_quota(input int t, input int q);
    i_cfg_we = 1'b1;
    i_cfg_tenant = TIDW'(t);
    i_cfg_quota = QW'(q);
    cyc();
  endtask

  initial begin
    int n, acc_cnt;
    longint d0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push", o_push, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_push_data", o_push_data, 0);
    chk("rst_drop_tenant", o_drop_tenant, 0);
    chk("rst_global", o_global_cnt, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_err", o_err, 0);
    i_arst = 1'b0;

    // Three back-to-back tenant-2 requests with fixed latency.
    pend.push_back(mk_req(2, 16'h0100));
    pend.push_back(mk_req(2, 16'h0200));
    pend.push_back(mk_req(2, 16'h0300));
    cyc();
    chk("lat_c1_push", o_push, 0);
    cyc();
    chk("lat_c2_push", o_push, 1);
    chk("lat_c2_prio", o_push_data[PTW-1:0], 16'h0100);
    cyc();
    chk("lat_c3_prio", o_push_data[PTW-1:0], 16'h0200);
    cyc();
    chk("lat_c4_prio", o_push_data[PTW-1:0], 16'h0300);
    drain(50);
    chk("t2_global", o_global_cnt, 3);

    // Quota 2 for tenant 5: two pushes then two drops.
    set_quota(5, 2);
    for (int i = 0; i < 4; i++) pend.push_back(mk_req(5, 16'(i)));
    drain(50);
    chk("t5_drop_cnt", o_drop_cnt, 2);
    chk("t5_drop_tenant", o_drop_tenant, 5);

    // Hold: FIFO fills to DEPTH, then ready falls.
    i_hold = 1'b1;
    for (int i = 0; i < 6; i++) pend.push_back(mk_req(1, 16'(100 + i)));
    repeat (6) cyc();
    acc_cnt = 6 - pend.size();
    chk("hold_accepts", acc_cnt, 4);
    chk("hold_ready_low", o_in_ready, 0);
    i_hold = 1'b0;
    drain(50);

    // Tenant 3 at occ=quota=1: same-cycle departure does not make room.
    set_quota(3, 1);
    pend.push_back(mk_req(3, 16'h0033));
    drain(50);
    i_hold = 1'b1;
    pend.push_back(mk_req(3, 16'h0034));
    cyc();
    i_hold = 1'b0;
    i_deq_valid = 1'b1;
    i_deq_tenant = 4'd3;
    cyc();
    chk("t3_same_cycle_drop", o_drop, 1);
    pend.push_back(mk_req(3, 16'h0035));
    drain(50);

    // Departure of an empty tenant sets the sticky error.
    i_deq_valid = 1'b1;
    i_deq_tenant = 4'd7;
    cyc();
    chk("t7_err", o_err, 1);

    // Fill the PIFO to global capacity.
    for (int i = 0; i < TENANTS; i++) set_quota(i, 255);
    n = CAP - m_glob;
    for (int k = 0; k < n; k++) pend.push_back(mk_req(k % TENANTS, 16'(k)));
    drain(n + 100);
    chk("cap_global", o_global_cnt, CAP);
    d0 = m_dcnt;
    pend.push_back(mk_req(9, 16'h0999));
    drain(50);
    chk("cap_full_drop", o_drop_cnt, d0 + 1);
    i_deq_valid = 1'b1;
    i_deq_tenant = 4'd0;
    cyc();
    pend.push_back(mk_req(0, 16'h0AAA));
    drain(50);
    chk("cap_readmit", o_global_cnt, CAP);

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) pend.push_back(mk_req(4, 16'(i)));
    cyc();
    cyc();
    #2 i_arst = 1'b1;
    #1;
    chk("mid_rst_push", o_push, 0);
    chk("mid_rst_drop", o_drop, 0);
    chk("mid_rst_global", o_global_cnt, 0);
    chk("mid_rst_drop_cnt", o_drop_cnt, 0);
    chk("mid_rst_err", o_err, 0);
    chk("mid_rst_push_data", o_push_data, 0);
    model_reset();
    pend.delete();
    i_in_valid = 1'b0;
    @(posedge clk);
    #1 i_arst = 1'b0;
    cyc();
    cyc();

    // Randomized traffic with departures, holds and quota changes.
    for (int c = 0; c < 800; c++) begin
      int t;
      if (pend.size() < 3 && ($urandom % 3) != 0)
        pend.push_back(mk_req(int'($urandom % TENANTS), 16'($urandom)));
      i_hold = (($urandom % 5) == 0);
      t = int'($urandom % TENANTS);
      if (m_occ[t] > 0 && ($urandom % 2) == 0) begin
        i_deq_valid = 1'b1;
        i_deq_tenant = TIDW'(t);
      end
      if (($urandom % 30) == 0) begin
        i_cfg_we = 1'b1;
        i_cfg_tenant = TIDW'($urandom % TENANTS);
        i_cfg_quota = QW'($urandom % 8);
      end
      cyc();
    end
    i_hold = 1'b0;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
